fan_speed_scanner: RTL and testbench

//  Round-robin poller for the 4-fan read mux: drives one-hot fan_selection/read, captures
//  the returned speed, keeps a per-fan speed register file. Serves host reads through a
//  req/ack handshake. Sits between the fan speed datapath and the ARM peripheral bus.

---
 rtl/fan_scan_pkg.sv | 25 ++
 rtl/fan_stall_detector.sv | 43 ++++
 rtl/fan_speed_scanner.sv | 139 +++++++++++++
 tb/tb_fan_speed_scanner.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_scan_pkg.sv
// Shared types and constants for the fan speed scanner.
// Latency: none (package only).
// Backpressure: none (package only).
package fan_scan_pkg;

  // Poll sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    SELECT  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int         NUM_FANS = 4;
  // Code the mux returns when a fan read fails; stored as-is, never a slow sample
  localparam logic [7:0] FAN_FAIL = 8'hFF;

  // Fan index to one-hot mux select
  function automatic logic [NUM_FANS-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [NUM_FANS-1:0] v;
    v = 4'b0001;
    return v << idx;
  endfunction

endpackage

// File: rtl/fan_stall_detector.sv
// Per-fan stall detector: counts consecutive slow captures and raises a sticky flag.
// Latency: flag sets on the clock edge of the capture that reaches the limit.
// Backpressure: none; a set on the same edge as a clear takes priority.
module fan_stall_detector
  import fan_scan_pkg::*;
#(
  parameter logic [7:0] STALL_THRESH = 8'h10,
  parameter int         STALL_LIMIT  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cap,
  input  logic [7:0] i_speed,
  input  logic       i_clr,
  output logic       o_stall
);

  logic [2:0] r_cnt;
  logic       r_stall;
  logic       w_slow;
  logic [2:0] w_cnt_inc;
  logic       w_set;

  assign w_slow    = (i_speed < STALL_THRESH) && (i_speed != FAN_FAIL);
  assign w_cnt_inc = (r_cnt == 3'd7) ? 3'd7 : r_cnt + 3'd1;
  assign w_set     = i_cap && w_slow && (w_cnt_inc >= 3'(STALL_LIMIT));
  assign o_stall   = r_stall;

  // Saturating slow-sample counter and sticky stall flag; a capture outranks a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 3'd0;
      r_stall <= 1'b0;
    end else begin
      if (i_cap)      r_cnt <= w_slow ? w_cnt_inc : 3'd0;
      else if (i_clr) r_cnt <= 3'd0;

      if (w_set)      r_stall <= 1'b1;
      else if (i_clr) r_stall <= 1'b0;
    end
  end

endmodule

// File: rtl/fan_speed_scanner.sv
// Round-robin 4-fan speed poller with per-fan speed store, host read port; stall detect under FAN_SCAN_STALL_EN.
// Latency: one poll every SCAN_DIV+2 clocks; host ack one clock after an armed request.
// Backpressure: none; a held host_req yields one ack and must drop low to re-arm.
module fan_speed_scanner
  import fan_scan_pkg::*;
#(
  parameter int         SCAN_DIV     = 1000,
  parameter logic [7:0] STALL_THRESH = 8'h10,
  parameter int         STALL_LIMIT  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  output logic [NUM_FANS-1:0] fan_selection,
  output logic                read,
  input  logic [7:0]          speed_in,
  input  logic                host_req,
  input  logic [1:0]          host_sel,
  output logic                host_ack,
  output logic [7:0]          host_data,
  output logic [NUM_FANS-1:0] stall,
  output logic                irq,
  input  logic                irq_clr
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [1:0]          r_idx;
  logic [NUM_FANS-1:0] r_sel;
  logic                r_read;
  logic [7:0]          r_speed [NUM_FANS];
  logic                r_armed;
  logic                r_ack;
  logic [7:0]          r_hdata;
  logic                w_capture;

  assign w_capture     = (r_state == CAPTURE);
  assign fan_selection = r_sel;
  assign read          = r_read;
  assign host_ack      = r_ack;
  assign host_data     = r_hdata;

  // Poll sequencer: wait out the divider, then hold select/read for SELECT and CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_idx   <= 2'd0;
      r_sel   <= '0;
      r_read  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_div <= '0;
          if (enable) r_state <= WAIT;
        end
        WAIT: begin
          if (!enable) begin
            r_state <= IDLE;
            r_div   <= '0;
          end else if (r_div == DIV_LAST) begin
            r_state <= SELECT;
            r_div   <= '0;
            r_sel   <= idx_to_onehot(r_idx);
            r_read  <= 1'b1;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        SELECT: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_idx   <= r_idx + 2'd1;
          r_sel   <= '0;
          r_read  <= 1'b0;
          r_state <= enable ? WAIT : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Speed register file, written with the mux value at the end of CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FANS; i++) r_speed[i] <= 8'h00;
    end else if (w_capture) begin
      r_speed[r_idx] <= speed_in;
    end
  end

  // Host read: one ack per request level, returns the value stored before any same-cycle capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
      r_ack   <= 1'b0;
      r_hdata <= 8'h00;
    end else begin
      r_ack <= 1'b0;
      if (!host_req) begin
        r_armed <= 1'b1;
      end else if (r_armed) begin
        r_armed <= 1'b0;
        r_ack   <= 1'b1;
        r_hdata <= r_speed[host_sel];
      end
    end
  end

`ifdef FAN_SCAN_STALL_EN
  logic [NUM_FANS-1:0] w_stall;

  for (genvar g = 0; g < NUM_FANS; g++) begin : g_det
    fan_stall_detector #(
      .STALL_THRESH (STALL_THRESH),
      .STALL_LIMIT  (STALL_LIMIT)
    ) u_det (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_cap   (w_capture && (r_idx == 2'(g))),
      .i_speed (speed_in),
      .i_clr   (irq_clr),
      .o_stall (w_stall[g])
    );
  end

  assign stall = w_stall;
  assign irq   = |w_stall;
`else
  // Without stall detection irq_clr has nothing to clear; it only feeds a constant-zero term
  assign stall = {NUM_FANS{1'b0}} & {NUM_FANS{irq_clr}};
  assign irq   = 1'b0;
`endif

endmodule

// File: tb/tb_fan_speed_scanner.sv
// Self-checking bench for fan_speed_scanner with SCAN_DIV=4.
// Latency: poll every 6 clocks, host ack one clock after request.
// Backpressure: none.
module tb_fan_speed_scanner;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] fan_selection;
  logic       read;
  logic [7:0] speed_in;
  logic       host_req;
  logic [1:0] host_sel;
  logic       host_ack;
  logic [7:0] host_data;
  logic [3:0] stall;
  logic       irq;
  logic       irq_clr;

`ifdef FAN_SCAN_STALL_EN
  localparam logic [3:0] STALL3 = 4'b1000;
`else
  localparam logic [3:0] STALL3 = 4'b0000;
`endif
  localparam logic IRQ3 = |STALL3;

  logic [7:0] mux_spd [4];
  logic [3:0] sel_q [$];
  logic [7:0] data_q [$];

  int  n_cmp = 0;
  int  n_err = 0;
  int  n_ack = 0;
  int  cyc = 0;
  int  hold = 0;
  int  last_start = 0;
  bit  have_last = 0;
  bit  gap_en = 0;
  logic prev_read = 1'b0;

  fan_speed_scanner #(
    .SCAN_DIV     (4),
    .STALL_THRESH (8'h10),
    .STALL_LIMIT  (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .fan_selection (fan_selection),
    .read          (read),
    .speed_in      (speed_in),
    .host_req      (host_req),
    .host_sel      (host_sel),
    .host_ack      (host_ack),
    .host_data     (host_data),
    .stall         (stall),
    .irq           (irq),
    .irq_clr       (irq_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fan read mux model: combinational speed of the selected fan
  always_comb begin
    speed_in = 8'h00;
    case (fan_selection)
      4'b0001: speed_in = mux_spd[0];
      4'b0010: speed_in = mux_spd[1];
      4'b0100: speed_in = mux_spd[2];
      4'b1000: speed_in = mux_spd[3];
      default: speed_in = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: poll selection, poll spacing, hold length, host acks
  always @(negedge clk) begin
    cyc++;
    if (read && !prev_read) begin
      if (sel_q.size() > 0) chk("poll_sel", 32'(fan_selection), 32'(sel_q.pop_front()));
      if (gap_en && have_last) chk("poll_gap", 32'(cyc - last_start), 32'd6);
      last_start = cyc;
      have_last  = gap_en;
      hold       = 1;
    end else if (read) begin
      hold++;
    end else if (prev_read) begin
      chk("poll_hold", 32'(hold), 32'd2);
    end
    if (host_ack) begin
      n_ack++;
      if (data_q.size() > 0) chk("host_data", 32'(host_data), 32'(data_q.pop_front()));
      else chk("extra_ack", 32'(host_ack), 32'd0);
    end
    prev_read = read;
  end

  task automatic drain(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (sel_q.size() == 0) && (data_q.size() == 0);
    end
    chk(tag, 32'(done), 32'd1);
    sel_q.delete();
    data_q.delete();
  endtask

  // Returns at the negedge of the SELECT cycle of a poll of fan 'want'
  task automatic wait_sel(input logic [3:0] want);
    bit   found;
    logic p;
    found = 0;
    p = read;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = read && !p && (fan_selection == want);
      p = read;
    end
    chk("wait_sel", 32'(found), 32'd1);
  endtask

  // Returns at the negedge just after the capture of fan 'want'
  task automatic wait_cap(input logic [3:0] want);
    wait_sel(want);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic host_read(input logic [1:0] s, input logic [7:0] exp);
    data_q.push_back(exp);
    host_sel = s;
    host_req = 1'b1;
    @(negedge clk);
    host_req = 1'b0;
    drain("host_read_done");
  endtask

  initial begin
    int t;
    int a0;
    rst_n = 1'b0; enable = 1'b0; host_req = 1'b0; host_sel = 2'd0; irq_clr = 1'b0;
    mux_spd[0] = 8'h11; mux_spd[1] = 8'h22; mux_spd[2] = 8'h33; mux_spd[3] = 8'h44;
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(fan_selection), 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_ack", 32'(host_ack), 32'd0);
    chk("rst_data", 32'(host_data), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: round-robin polling and host reads of each fan
    gap_en = 1;
    sel_q.push_back(4'b0001); sel_q.push_back(4'b0010); sel_q.push_back(4'b0100);
    sel_q.push_back(4'b1000); sel_q.push_back(4'b0001);
    enable = 1'b1;
    t = 0;
    while (!read && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("first_poll_lat", 32'(t), 32'd5);
    drain("sweep_done");
    gap_en = 0;
    host_read(2'd0, 8'h11);
    host_read(2'd1, 8'h22);
    host_read(2'd2, 8'h33);
    host_read(2'd3, 8'h44);

    // 2: held request gives one ack; re-raise gives another
    a0 = n_ack;
    data_q.push_back(8'h33);
    host_sel = 2'd2;
    host_req = 1'b1;
    repeat (10) @(negedge clk);
    host_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_req_acks", 32'(n_ack - a0), 32'd1);
    repeat (4) @(negedge clk);
    chk("host_data_hold", 32'(host_data), 32'h33);
    host_read(2'd2, 8'h33);

    // 3: enable dropped in SELECT of fan1 lets the poll complete, then idles
    wait_sel(4'b0010);
    enable = 1'b0;
    mux_spd[1] = 8'h5A;
    @(negedge clk);
    chk("drop_capture_read", 32'(read), 32'd1);
    @(negedge clk);
    chk("drop_after_read", 32'(read), 32'd0);
    chk("drop_after_sel", 32'(fan_selection), 32'd0);
    repeat (12) @(negedge clk);
    chk("idle_read", 32'(read), 32'd0);
    host_read(2'd1, 8'h5A);
    sel_q.push_back(4'b0100);
    enable = 1'b1;
    drain("resume_poll");

    // 4: stall detection on fan3
    mux_spd[3] = 8'h05;
    wait_cap(4'b1000);
    wait_cap(4'b1000);
    chk("stall_two_slow", 32'(stall), 32'd0);
    mux_spd[3] = 8'h20;
    wait_cap(4'b1000);
    mux_spd[3] = 8'h05;
    wait_cap(4'b1000);
    wait_cap(4'b1000);
    chk("stall_after_fast", 32'(stall), 32'd0);
    wait_cap(4'b1000);
    chk("stall_set", 32'(stall), 32'(STALL3));
    chk("irq_set", 32'(irq), 32'(IRQ3));
    mux_spd[3] = 8'h20;
    wait_cap(4'b1000);
    chk("stall_sticky", 32'(stall), 32'(STALL3));
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("stall_clr", 32'(stall), 32'd0);
    chk("irq_clr", 32'(irq), 32'd0);
    mux_spd[3] = 8'h05;
    wait_cap(4'b1000);
    wait_cap(4'b1000);
    mux_spd[3] = 8'hFF;
    wait_cap(4'b1000);
    host_read(2'd3, 8'hFF);
    mux_spd[3] = 8'h05;
    wait_cap(4'b1000);
    chk("fail_code_clears", 32'(stall), 32'd0);
    wait_cap(4'b1000);
    wait_sel(4'b1000);
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("set_beats_clr", 32'(stall), 32'(STALL3));
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("stall_clr2", 32'(stall), 32'd0);

    // 6: host read on the capture edge returns the old value
    wait_sel(4'b0001);
    mux_spd[0] = 8'h77;
    @(negedge clk);
    data_q.push_back(8'h11);
    host_sel = 2'd0;
    host_req = 1'b1;
    @(negedge clk);
    host_req = 1'b0;
    drain("same_cycle_read");
    host_read(2'd0, 8'h77);

    // 5: reset during CAPTURE
    wait_sel(4'b0010);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst_sel", 32'(fan_selection), 32'd0);
    chk("arst_read", 32'(read), 32'd0);
    chk("arst_ack", 32'(host_ack), 32'd0);
    chk("arst_data", 32'(host_data), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    host_read(2'd0, 8'h00);
    host_read(2'd1, 8'h00);
    host_read(2'd2, 8'h00);
    host_read(2'd3, 8'h00);
    sel_q.push_back(4'b0001);
    enable = 1'b1;
    drain("post_reset_poll");

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
